// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port between the fetch stage and instruction memory.
// The fetch stage drives the request and the memory answers with ready/rdata.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, one-word hold buffer,
// and redirect handling while a fetch is still outstanding (DRAIN).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          stall_d,
  input  logic          flush_d,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instr_d,
  output logic [5:0]    opcode_d,
  output logic [31:0]   pc_plus4_d,
  output logic          valid_d
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] instr_q, instr_nx;
  logic [31:0] pc_plus4_q, pc_plus4_nx;
  logic        valid_q, valid_nx;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic        accept_s;
  logic        kill_s;
  logic [31:0] redir_aligned_s;
  logic        load_s;
  logic [31:0] load_word_s;
  logic [31:0] load_pc4_s;

  assign accept_s        = ~stall_d;
  assign kill_s          = flush_d | redirect_valid;
  assign redir_aligned_s = redirect_pc & 32'hFFFF_FFFC;

  // Fetch FSM next state, PC update and selection of the word offered to IF/ID.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    hold_pc4_d  = hold_pc4_q;
    redir_pc_d  = redir_pc_q;
    load_s      = 1'b0;
    load_word_s = imem.imem_rdata;
    load_pc4_s  = pc_q + 32'd4;
    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ready) begin
          if (redirect_valid) begin
            pc_d = redir_aligned_s;
          end else if (accept_s) begin
            load_s = 1'b1;
            pc_d   = pc_q + 32'd4;
          end else begin
            hold_d     = imem.imem_rdata;
            hold_pc4_d = pc_q + 32'd4;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_HOLD;
          end
        end else if (redirect_valid) begin
          redir_pc_d = redir_aligned_s;
          state_d    = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        load_word_s = hold_q;
        load_pc4_s  = hold_pc4_q;
        if (redirect_valid) begin
          pc_d    = redir_aligned_s;
          state_d = ST_FETCH;
        end else if (accept_s) begin
          load_s  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The newest redirect wins, even in the cycle the stale word returns.
        if (redirect_valid) begin
          redir_pc_d = redir_aligned_s;
        end else begin
          redir_pc_d = redir_pc_q;
        end
        if (imem.imem_ready) begin
          pc_d    = redirect_valid ? redir_aligned_s : redir_pc_q;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  // IF/ID register next values: kill beats stall beats load beats bubble.
  always_comb begin
    instr_nx    = instr_q;
    pc_plus4_nx = pc_plus4_q;
    valid_nx    = valid_q;
    if (kill_s) begin
      valid_nx = 1'b0;
      instr_nx = NOP_INSTR;
    end else if (stall_d) begin
      valid_nx = valid_q;
    end else if (load_s) begin
      valid_nx    = 1'b1;
      instr_nx    = load_word_s;
      pc_plus4_nx = load_pc4_s;
    end else begin
      valid_nx = 1'b0;
      instr_nx = NOP_INSTR;
    end
  end

  // Memory request is registered from the next state so it is glitch-free and stable.
  always_comb begin
    req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    addr_d = pc_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_START;
      pc_q       <= RESET_PC;
      hold_q     <= NOP_INSTR;
      hold_pc4_q <= 32'd0;
      redir_pc_q <= 32'd0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      hold_pc4_q <= hold_pc4_d;
      redir_pc_q <= redir_pc_d;
      instr_q    <= instr_nx;
      pc_plus4_q <= pc_plus4_nx;
      valid_q    <= valid_nx;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr_d        = instr_q;
  assign opcode_d       = instr_q[31:26];
  assign pc_plus4_d     = pc_plus4_q;
  assign valid_d        = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked
// against a queue-based transaction model of the fetch/IF-ID behaviour.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_d, flush_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pc_plus4_d;
  logic [5:0]  opcode_d;
  logic        valid_d;
  logic [31:0] scramble;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_d        (instr_d),
    .opcode_d       (opcode_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_started, m_drain, m_valid;
  logic [31:0] m_pc, m_redir, m_instr, m_pc4;
  logic [31:0] m_hold_w[$];
  logic [31:0] m_hold_p[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ scramble;
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_drain = 1'b0; m_valid = 1'b0;
    m_pc = RESET_PC; m_redir = 32'd0; m_instr = NOP; m_pc4 = 32'd0;
    m_hold_w.delete(); m_hold_p.delete();
  endtask

  task automatic model_step();
    bit          acc, kill, load, rdy;
    logic [31:0] rpc, w, p4;
    acc  = !stall_d;
    kill = flush_d || redirect_valid;
    rdy  = imem.imem_ready;
    rpc  = redirect_pc & 32'hFFFF_FFFC;
    load = 1'b0; w = NOP; p4 = 32'd0;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_hold_w.size() > 0) begin
      if (redirect_valid) begin
        m_hold_w.delete(); m_hold_p.delete(); m_pc = rpc;
      end else if (acc) begin
        load = 1'b1; w = m_hold_w.pop_front(); p4 = m_hold_p.pop_front();
      end
    end else if (m_drain) begin
      if (redirect_valid) m_redir = rpc;
      if (rdy) begin m_pc = m_redir; m_drain = 1'b0; end
    end else if (rdy) begin
      if (redirect_valid) m_pc = rpc;
      else if (acc) begin load = 1'b1; w = imem.imem_rdata; p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; end
      else begin m_hold_w.push_back(imem.imem_rdata); m_hold_p.push_back(m_pc + 32'd4); m_pc = m_pc + 32'd4; end
    end else if (redirect_valid) begin
      m_redir = rpc; m_drain = 1'b1;
    end
    if (kill) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (!stall_d) begin
      if (load) begin m_valid = 1'b1; m_instr = w; m_pc4 = p4; end
      else begin m_valid = 1'b0; m_instr = NOP; end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_op;
    exp_op = {26'd0, m_instr[31:26]};
    check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    check("instr_d", instr_d, m_instr);
    check("opcode_d", {26'd0, opcode_d}, exp_op);
    check("pc_plus4_d", pc_plus4_d, m_pc4);
    check("imem_req", {31'd0, imem.imem_req}, {31'd0, (m_started && m_hold_w.size() == 0)});
    if (imem.imem_req) check("imem_addr", imem.imem_addr, m_pc);
  endtask

  task automatic cycle(input bit st, input bit fl, input bit rv, input logic [31:0] rp, input bit want_ready);
    @(negedge clk);
    stall_d = st; flush_d = fl; redirect_valid = rv; redirect_pc = rp;
    imem.imem_ready = want_ready & imem.imem_req;
    imem.imem_rdata = imem.imem_ready ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet_inputs();
    stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem.imem_ready = 1'b0; imem.imem_rdata = 32'd0;
  endtask

  initial begin
    scramble = 32'd0;
    quiet_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_valid", {31'd0, valid_d}, 32'd0);
    check("reset_instr", instr_d, NOP);
    check("reset_pc4", pc_plus4_d, 32'd0);
    check("reset_req", {31'd0, imem.imem_req}, 32'd0);

    // Zero-wait streaming from reset
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("start_addr", imem.imem_addr, RESET_PC);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("stream0", instr_d, 32'h0040_0000);
    check("stream0_v", {31'd0, valid_d}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("stream1", instr_d, 32'h0040_0004);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("stream2", instr_d, 32'h0040_0008);
    check("stream2_pc4", pc_plus4_d, 32'h0040_000C);

    // Stall for three cycles with memory ready
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    check("stall_frozen", instr_d, 32'h0040_0008);
    check("stall_req0", {31'd0, imem.imem_req}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    check("stall_req1", {31'd0, imem.imem_req}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("held_word", instr_d, 32'h0040_000C);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("after_held", instr_d, 32'h0040_0010);

    // Redirect while fetch outstanding -> DRAIN
    cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
    check("drain_kill", {31'd0, valid_d}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("drain_stale", {31'd0, valid_d}, 32'd0);
    check("drain_newaddr", imem.imem_addr, 32'h0040_0100);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("redir_word", instr_d, 32'h0040_0100);

    // Flush together with stall
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    check("flush_stall_v", {31'd0, valid_d}, 32'd0);
    check("flush_stall_i", instr_d, NOP);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("flush_continue", instr_d, 32'h0040_0104);
    check("flush_continue_v", {31'd0, valid_d}, 32'd1);

    // Asynchronous reset while holding a word
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, valid_d}, 32'd0);
    check("async_instr", instr_d, NOP);
    check("async_pc4", pc_plus4_d, 32'd0);
    check("async_req", {31'd0, imem.imem_req}, 32'd0);
    model_reset();
    quiet_inputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_reset_req", {31'd0, imem.imem_req}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("post_reset_addr", imem.imem_addr, RESET_PC);

    // PC wrap-around, also exercising low-bit masking of redirect_pc
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    check("wrap_redir_addr", imem.imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("wrap_instr", instr_d, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_d, 32'd0);
    check("wrap_addr", imem.imem_addr, 32'd0);

    // Random traffic
    scramble = 32'hFC00_0003;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 11) == 0), $urandom(), ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
